lcd_mmio_ctrl: RTL and testbench

Memory-mapped HD44780-style character LCD controller for the single-cycle SoC. Replaces software bit-banging of the LCD data, control and enable lines. CPU byte stores are queued in a parametrised FIFO. A timing state machine generates setup, enable-pulse, hold and settle intervals in 8-bit or 4-bit bus mode. A status register lets firmware poll busy, full, empty and overflow.

---
 rtl/lcd_mmio_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_lcd_mmio_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_mmio_ctrl.sv
// rtl/lcd_mmio_ctrl.sv - memory-mapped HD44780-style character LCD controller
//
// Purpose: CPU byte stores to DATA/CMD are queued in a FIFO and replayed onto an
// HD44780-style bus with setup, enable-pulse, hold and settle intervals, in either
// 8-bit mode or 4-bit mode (high nibble first on lcd_data[7:4]).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   sel                 peripheral select for the MMIO window
//   addr[1:0]           register offset: 0 DATA(W), 1 CMD(W), 2 STATUS(R), 3 CTRL(W)
//   wdata[31:0]         store data, only [7:0] used
//   wenable[3:0]        byte strobes, only [0] qualifies a write
//   rdata[31:0]         combinational read data for addr
//   lcd_data[7:0]       LCD data bus (registered)
//   lcd_ctrl[1:0]       {RS, RW}, RW always 0 (registered)
//   lcd_enable          LCD E strobe (registered)

module lcd_mmio_ctrl #(
   parameter int FIFO_DEPTH    = 8,
   parameter int SETUP_CYCLES  = 2,
   parameter int PULSE_CYCLES  = 4,
   parameter int HOLD_CYCLES   = 2,
   parameter int SETTLE_CYCLES = 40,
   parameter int NIBBLE_MODE   = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sel,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wenable,
   output logic [31:0] rdata,
   output logic [7:0]  lcd_data,
   output logic [1:0]  lcd_ctrl,
   output logic        lcd_enable
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = 16;

   // Timer load values are "cycles - 1": the state is left when the timer reads 0.
   localparam logic [TMR_W-1:0] SETUP_LD  = TMR_W'(SETUP_CYCLES - 1);
   localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PULSE_CYCLES - 1);
   localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      PULSE  = 3'd2,
      HOLD   = 3'd3,
      SETTLE = 3'd4
   } state_t;

   // ---------------------------------------------------------------- bus decode
   logic wr, push_req, ctrl_wr, flush, clr_ovf;

   assign wr       = sel && wenable[0];
   assign push_req = wr && ((addr == 2'd0) || (addr == 2'd1));
   assign ctrl_wr  = wr && (addr == 2'd3);
   assign flush    = ctrl_wr && wdata[0];
   assign clr_ovf  = ctrl_wr && wdata[1];

   logic unused_bits;
   assign unused_bits = ^{wdata[31:8], wenable[3:1]};

   // ---------------------------------------------------------------- FIFO
   // Entry format: {RS, byte}; RS=1 for DATA, 0 for CMD.
   logic [8:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             full, empty, push, pop;
   logic [8:0]       head;

   state_t state, state_nxt;

   assign full  = (count == CNT_W'(FIFO_DEPTH));
   assign empty = (count == '0);
   // Full is judged before any same-cycle pop, so a push into a full FIFO drops.
   assign push  = push_req && !full;
   assign pop   = (state == IDLE) && !empty;
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {(addr == 2'd0), wdata[7:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (flush) begin
            // Flush discards queued entries only; a popped entry is already latched.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end

         if (clr_ovf) begin
            overflow <= 1'b0;
         end else if (push_req && full) begin
            overflow <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- timing FSM
   logic [TMR_W-1:0] tmr, tmr_nxt;
   logic             tmr_done;
   logic [7:0]       byte_q, byte_nxt;
   logic             lo_pend, lo_nxt;     // low nibble still to be sent
   logic [7:0]       data_nxt;
   logic [1:0]       ctrl_nxt;
   logic             en_nxt;

   assign tmr_done = (tmr == '0);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (!empty) state_nxt = SETUP;
         SETUP:  if (tmr_done) state_nxt = PULSE;
         PULSE:  if (tmr_done) state_nxt = HOLD;
         HOLD: begin
            if (tmr_done) begin
               if (lo_pend)                 state_nxt = SETUP;
               else if (SETTLE_CYCLES == 0) state_nxt = IDLE;
               else                         state_nxt = SETTLE;
            end
         end
         SETTLE: if (tmr_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      tmr_nxt  = tmr_done ? tmr : tmr - TMR_W'(1);
      byte_nxt = byte_q;
      lo_nxt   = lo_pend;
      data_nxt = lcd_data;
      ctrl_nxt = lcd_ctrl;
      en_nxt   = (state_nxt == PULSE);

      if (state_nxt != state) begin
         case (state_nxt)
            SETUP:   tmr_nxt = SETUP_LD;
            PULSE:   tmr_nxt = PULSE_LD;
            HOLD:    tmr_nxt = HOLD_LD;
            SETTLE:  tmr_nxt = SETTLE_LD;
            default: tmr_nxt = '0;
         endcase
      end

      if (pop) begin
         byte_nxt = head[7:0];
         lo_nxt   = (NIBBLE_MODE != 0);
         ctrl_nxt = {head[8], 1'b0};
         data_nxt = (NIBBLE_MODE != 0) ? {head[7:4], 4'b0000} : head[7:0];
      end else if ((state == HOLD) && tmr_done && lo_pend) begin
         lo_nxt   = 1'b0;
         data_nxt = {byte_q[3:0], 4'b0000};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmr        <= '0;
         byte_q     <= '0;
         lo_pend    <= 1'b0;
         lcd_data   <= '0;
         lcd_ctrl   <= '0;
         lcd_enable <= 1'b0;
      end else begin
         tmr        <= tmr_nxt;
         byte_q     <= byte_nxt;
         lo_pend    <= lo_nxt;
         lcd_data   <= data_nxt;
         lcd_ctrl   <= ctrl_nxt;
         lcd_enable <= en_nxt;
      end
   end

   // ---------------------------------------------------------------- read mux
   logic       busy;
   logic [7:0] count_byte;

   assign busy       = (state != IDLE) || !empty;
   assign count_byte = 8'(count);

   always_comb begin
      rdata = '0;
      if (addr == 2'd2) begin
         rdata = {16'h0000, count_byte, 4'b0000, overflow, empty, full, busy};
      end
   end

endmodule

// File: tb/tb_lcd_mmio_ctrl.sv
// tb/tb_lcd_mmio_ctrl.sv - directed self-checking bench for lcd_mmio_ctrl

module tb_lcd_mmio_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel0, sel1, sel2;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  wenable;
   logic [31:0] rdata0, rdata1, rdata2;
   logic [7:0]  data0, data1, data2;
   logic [1:0]  ctrl0, ctrl1, ctrl2;
   logic        en0, en1, en2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lcd_mmio_ctrl u0 (
      .clk(clk), .rst_n(rst_n), .sel(sel0), .addr(addr), .wdata(wdata),
      .wenable(wenable), .rdata(rdata0), .lcd_data(data0), .lcd_ctrl(ctrl0),
      .lcd_enable(en0));

   lcd_mmio_ctrl #(.FIFO_DEPTH(4)) u1 (
      .clk(clk), .rst_n(rst_n), .sel(sel1), .addr(addr), .wdata(wdata),
      .wenable(wenable), .rdata(rdata1), .lcd_data(data1), .lcd_ctrl(ctrl1),
      .lcd_enable(en1));

   lcd_mmio_ctrl #(.NIBBLE_MODE(1)) u2 (
      .clk(clk), .rst_n(rst_n), .sel(sel2), .addr(addr), .wdata(wdata),
      .wenable(wenable), .rdata(rdata2), .lcd_data(data2), .lcd_ctrl(ctrl2),
      .lcd_enable(en2));

   // Enable-edge log per instance
   int         rise_cyc [3][$];
   int         fall_cyc [3][$];
   logic [7:0] rise_dat [3][$];
   logic [1:0] rise_ctl [3][$];
   logic [2:0] en_prev = 3'b000;

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         logic       e;
         logic [7:0] d;
         logic [1:0] c;
         e = (i == 0) ? en0 : (i == 1) ? en1 : en2;
         d = (i == 0) ? data0 : (i == 1) ? data1 : data2;
         c = (i == 0) ? ctrl0 : (i == 1) ? ctrl1 : ctrl2;
         if (e && !en_prev[i]) begin
            rise_cyc[i].push_back(cyc);
            rise_dat[i].push_back(d);
            rise_ctl[i].push_back(c);
         end
         if (!e && en_prev[i]) fall_cyc[i].push_back(cyc);
      end
      en_prev <= {en2, en1, en0};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; the write lands on the next posedge.
   task automatic wr(input int inst, input logic [1:0] a, input logic [7:0] d, output int w);
      addr    = a;
      wdata   = {24'h0, d};
      wenable = 4'h1;
      sel0    = (inst == 0);
      sel1    = (inst == 1);
      sel2    = (inst == 2);
      @(negedge clk);
      w       = cyc;
      sel0    = 1'b0;
      sel1    = 1'b0;
      sel2    = 1'b0;
      wenable = 4'h0;
   endtask

   task automatic st(input int inst, output logic [31:0] v);
      addr = 2'd2;
      #1;
      v = (inst == 0) ? rdata0 : (inst == 1) ? rdata1 : rdata2;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   initial begin
      int          w, w0, b, fb;
      logic [31:0] s;

      rst_n = 1'b0; sel0 = 0; sel1 = 0; sel2 = 0;
      addr = 2'd0; wdata = '0; wenable = 4'h0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_enable", en0, 1'b0);
      check("rst_data", data0, 8'h00);
      check("rst_ctrl", ctrl0, 2'b00);
      st(0, s); check("rst_status", s, 32'h4);
      st(1, s); check("rst_status_d4", s, 32'h4);
      rst_n = 1'b1;
      @(negedge clk);

      // Single DATA write, default timing
      b = rise_cyc[0].size(); fb = fall_cyc[0].size();
      wr(0, 2'd0, 8'h41, w);
      wait_to(w + 48);
      st(0, s); check("t1_busy_before", s[0], 1'b1);
      @(negedge clk);
      st(0, s); check("t1_busy_after", s[0], 1'b0);
      repeat (5) @(negedge clk);
      check("t1_pulses", rise_cyc[0].size() - b, 1);
      check("t1_rise_lat", rise_cyc[0][b] - w, 3);
      check("t1_width", fall_cyc[0][fb] - rise_cyc[0][b], 4);
      check("t1_data", rise_dat[0][b], 8'h41);
      check("t1_ctrl", rise_ctl[0][b], 2'b10);

      // CMD then two DATA back-to-back
      b = rise_cyc[0].size();
      wr(0, 2'd1, 8'h01, w);
      wr(0, 2'd0, 8'h48, w0);
      wr(0, 2'd0, 8'h49, w0);
      repeat (160) @(negedge clk);
      check("t2_pulses", rise_cyc[0].size() - b, 3);
      check("t2_rise_lat", rise_cyc[0][b] - w, 3);
      check("t2_gap1", rise_cyc[0][b+1] - rise_cyc[0][b], 49);
      check("t2_gap2", rise_cyc[0][b+2] - rise_cyc[0][b+1], 49);
      check("t2_ctrl0", rise_ctl[0][b], 2'b00);
      check("t2_ctrl1", rise_ctl[0][b+1], 2'b10);
      check("t2_ctrl2", rise_ctl[0][b+2], 2'b10);
      check("t2_data0", rise_dat[0][b], 8'h01);
      check("t2_data2", rise_dat[0][b+2], 8'h49);

      // FIFO_DEPTH=4 overflow
      b = rise_cyc[1].size();
      for (int i = 0; i < 10; i++) wr(1, 2'd0, 8'(i + 1), w);
      st(1, s); check("t3_status_ovf", s, 32'h40B);
      wr(1, 2'd3, 8'h02, w);
      st(1, s); check("t3_status_clr", s, 32'h403);
      repeat (5 * 49 + 20) @(negedge clk);
      check("t3_pulses", rise_cyc[1].size() - b, 5);
      check("t3_first", rise_dat[1][b], 8'h01);
      check("t3_last", rise_dat[1][b+4], 8'h05);
      st(1, s); check("t3_status_end", s, 32'h4);

      // Nibble mode
      b = rise_cyc[2].size();
      wr(2, 2'd0, 8'hA5, w);
      repeat (80) @(negedge clk);
      check("t4_pulses", rise_cyc[2].size() - b, 2);
      check("t4_rise_lat", rise_cyc[2][b] - w, 3);
      check("t4_hi", rise_dat[2][b], 8'hA0);
      check("t4_lo", rise_dat[2][b+1], 8'h50);
      check("t4_rs_lo", rise_ctl[2][b+1], 2'b10);
      check("t4_gap", rise_cyc[2][b+1] - rise_cyc[2][b], 8);

      // Flush during first pulse
      b = rise_cyc[0].size();
      wr(0, 2'd0, 8'h11, w0);
      wr(0, 2'd0, 8'h22, w);
      wr(0, 2'd0, 8'h33, w);
      @(negedge clk);
      check("t5_in_pulse", en0, 1'b1);
      wr(0, 2'd3, 8'h01, w);
      st(0, s); check("t5_status_flush", s, 32'h5);
      repeat (120) @(negedge clk);
      check("t5_pulses", rise_cyc[0].size() - b, 1);
      check("t5_data", rise_dat[0][b], 8'h11);
      st(0, s); check("t5_status_end", s, 32'h4);

      // Reset during PULSE
      wr(0, 2'd0, 8'h77, w);
      wait_to(w + 4);
      check("t6_in_pulse", en0, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_enable", en0, 1'b0);
      check("t6_data", data0, 8'h00);
      check("t6_ctrl", ctrl0, 2'b00);
      st(0, s); check("t6_status", s, 32'h4);
      rst_n = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
